// File: rtl/copter_cmd_responder.sv
// rtl/copter_cmd_responder.sv - copter-side 3-byte command responder; CMD_WDOG_EN adds a comm-loss watchdog
module copter_cmd_responder #(
    parameter int          SPINUP_W = 25,
    parameter int          WDOG_W   = 26,
    parameter logic [7:0]  POS_ACK  = 8'hA5,
    parameter logic [7:0]  NEG_ACK  = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    input  logic        resp_sent,
    output logic        strt_cnv,
    input  logic        cnv_cmplt,
    input  logic [7:0]  batt,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic        inertial_cal,
    output logic        motors_off,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPINUP    = 3'd1,
        CAL       = 3'd2,
        BATT      = 3'd3,
        RESP      = 3'd4,
        WAIT_SENT = 3'd5
    } state_t;

    localparam logic [SPINUP_W-1:0] SPIN_ONE = 1;

    state_t              state_q, state_d;
    logic [15:0]         ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [8:0]          thrst_q, thrst_d;
    logic                motors_off_q, motors_off_d;
    logic                inertial_cal_q, inertial_cal_d;
    logic [7:0]          resp_q, resp_d;
    logic                send_resp_q, send_resp_d;
    logic [SPINUP_W-1:0] spin_cnt_q, spin_cnt_d;
    logic                wdog_hit;

`ifdef CMD_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_ONE  = 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = ~WDOG_ONE;

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Fires once, on the clock where the counter saturates.
    always_comb begin
        wdog_d   = wdog_q;
        wdog_hit = 1'b0;
        if (cmd_rdy) begin
            wdog_d = '0;
        end else if (wdog_q != '1) begin
            wdog_d   = wdog_q + WDOG_ONE;
            wdog_hit = (wdog_q == WDOG_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`else
    assign wdog_hit = 1'b0;
    if (WDOG_W < 1) begin : g_wdog_w_unused
    end
`endif

    always_comb begin
        state_d        = state_q;
        ptch_d         = ptch_q;
        roll_d         = roll_q;
        yaw_d          = yaw_q;
        thrst_d        = thrst_q;
        motors_off_d   = motors_off_q;
        inertial_cal_d = inertial_cal_q;
        resp_d         = resp_q;
        spin_cnt_d     = spin_cnt_q;
        send_resp_d    = 1'b0;
        clr_cmd_rdy    = 1'b0;
        strt_cnv       = 1'b0;
        strt_cal       = 1'b0;

        // A command decoded in the same clock overrides the watchdog zeroing below.
        if (wdog_hit) begin
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    resp_d      = POS_ACK;
                    state_d     = RESP;
                    case (cmd)
                        8'h01: begin
                            resp_d   = resp_q;
                            strt_cnv = 1'b1;
                            state_d  = BATT;
                        end
                        8'h02: ptch_d  = data;
                        8'h03: roll_d  = data;
                        8'h04: yaw_d   = data;
                        8'h05: thrst_d = data[8:0];
                        8'h06: begin
                            resp_d         = resp_q;
                            motors_off_d   = 1'b0;
                            inertial_cal_d = 1'b1;
                            spin_cnt_d     = '0;
                            state_d        = SPINUP;
                        end
                        8'h07: begin
                            ptch_d  = '0;
                            roll_d  = '0;
                            yaw_d   = '0;
                            thrst_d = '0;
                        end
                        8'h08: motors_off_d = 1'b1;
                        default: resp_d = NEG_ACK;
                    endcase
                end
            end
            SPINUP: begin
                if (&spin_cnt_q) begin
                    strt_cal = 1'b1;
                    state_d  = CAL;
                end else begin
                    spin_cnt_d = spin_cnt_q + SPIN_ONE;
                end
            end
            CAL: begin
                if (cal_done) begin
                    inertial_cal_d = 1'b0;
                    resp_d         = POS_ACK;
                    state_d        = RESP;
                end
            end
            BATT: begin
                if (cnv_cmplt) begin
                    resp_d  = batt;
                    state_d = RESP;
                end
            end
            RESP: begin
                send_resp_d = 1'b1;
                state_d     = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (resp_sent) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptch_q         <= '0;
            roll_q         <= '0;
            yaw_q          <= '0;
            thrst_q        <= '0;
            motors_off_q   <= 1'b1;
            inertial_cal_q <= 1'b0;
            resp_q         <= 8'h00;
            send_resp_q    <= 1'b0;
            spin_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            ptch_q         <= ptch_d;
            roll_q         <= roll_d;
            yaw_q          <= yaw_d;
            thrst_q        <= thrst_d;
            motors_off_q   <= motors_off_d;
            inertial_cal_q <= inertial_cal_d;
            resp_q         <= resp_d;
            send_resp_q    <= send_resp_d;
            spin_cnt_q     <= spin_cnt_d;
        end
    end

    assign send_resp    = send_resp_q;
    assign resp         = resp_q;
    assign inertial_cal = inertial_cal_q;
    assign motors_off   = motors_off_q;
    assign d_ptch       = ptch_q;
    assign d_roll       = roll_q;
    assign d_yaw        = yaw_q;
    assign thrst        = thrst_q;

endmodule

// File: tb/tb_copter_cmd_responder.sv
// tb/tb_copter_cmd_responder.sv - randomized self-checking bench for copter_cmd_responder
module tb_copter_cmd_responder;

    localparam int SPINUP_W = 4;
    localparam int WDOG_W   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        resp_sent = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [7:0]  batt = 8'h00;
    logic        cal_done = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cnv, strt_cal, inertial_cal, motors_off;
    logic [7:0]  resp;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;

    copter_cmd_responder #(.SPINUP_W(SPINUP_W), .WDOG_W(WDOG_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp), .resp_sent(resp_sent),
        .strt_cnv(strt_cnv), .cnv_cmplt(cnv_cmplt), .batt(batt), .strt_cal(strt_cal),
        .cal_done(cal_done), .inertial_cal(inertial_cal), .motors_off(motors_off),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int cal_delay = 20;
    int cnv_delay = 40;
    int t_strt_cal = -1;
    int t_strt_cnv = -1;
    int t_send = -1;
    int n_send = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what the copter should believe after each frame.
    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thrst;
    logic        m_moff;

    task automatic model_reset();
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; m_moff = 1'b1;
    endtask

    function automatic logic [7:0] model_apply(input logic [7:0] c, input logic [15:0] d,
                                               input logic [7:0] b);
        case (c)
            8'd1: return b;
            8'd2: m_ptch = d;
            8'd3: m_roll = d;
            8'd4: m_yaw = d;
            8'd5: m_thrst = 9'(d % 512);
            8'd6: m_moff = 1'b0;
            8'd7: begin m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; end
            8'd8: m_moff = 1'b1;
            default: return 8'hEE;
        endcase
        return 8'hA5;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_ptch"}, d_ptch, m_ptch);
        check({tag, "_roll"}, d_roll, m_roll);
        check({tag, "_yaw"}, d_yaw, m_yaw);
        check({tag, "_thrst"}, thrst, m_thrst);
        check({tag, "_moff"}, motors_off, m_moff);
    endtask

    // UART-side stub: knock down cmd_rdy after clr_cmd_rdy.
    initial forever begin
        @(negedge clk);
        if (clr_cmd_rdy) begin
            @(posedge clk); #1 cmd_rdy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (send_resp) n_send++;
    end

    // A2D stub.
    initial forever begin
        @(negedge clk);
        if (strt_cnv) begin
            t_strt_cnv = cyc;
            repeat (cnv_delay) @(posedge clk);
            #1 cnv_cmplt = 1'b1;
            @(posedge clk); #1 cnv_cmplt = 1'b0;
        end
    end

    // Inertial calibration stub.
    initial forever begin
        @(negedge clk);
        if (strt_cal) begin
            t_strt_cal = cyc;
            repeat (cal_delay) @(posedge clk);
            #1 cal_done = 1'b1;
            @(negedge clk) check("ical_before_done", inertial_cal, 1'b1);
            @(posedge clk); #1 cal_done = 1'b0;
            @(negedge clk) check("ical_after_done", inertial_cal, 1'b0);
        end
    end

    task automatic present(input logic [7:0] c, input logic [15:0] d, output int t0);
        @(posedge clk); #1;
        cmd = c; data = d; cmd_rdy = 1'b1; t0 = cyc;
    endtask

    task automatic await_resp(input logic [7:0] exp, input int t0, input bit chk_lat);
        bit seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (send_resp) begin seen = 1'b1; break; end
        end
        check("resp_seen", seen, 1'b1);
        if (seen) begin
            t_send = cyc;
            if (chk_lat) check("latency", cyc - t0, 2);
            check("resp", resp, exp);
            @(negedge clk) check("send_pulse_width", send_resp, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("resp_hold", resp, exp);
            @(posedge clk); #1 resp_sent = 1'b1;
            @(posedge clk); #1 resp_sent = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [15:0] d, input bit chk_lat);
        logic [7:0] exp;
        int t0;
        exp = model_apply(c, d, batt);
        present(c, d, t0);
        await_resp(exp, t0, chk_lat);
        check("cmd_rdy_cleared", cmd_rdy, 1'b0);
        check_state("frame");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ptch"}, d_ptch, 0);
        check({tag, "_roll"}, d_roll, 0);
        check({tag, "_yaw"}, d_yaw, 0);
        check({tag, "_thrst"}, thrst, 0);
        check({tag, "_moff"}, motors_off, 1'b1);
        check({tag, "_ical"}, inertial_cal, 1'b0);
        check({tag, "_resp"}, resp, 8'h00);
        check({tag, "_send"}, send_resp, 1'b0);
        check({tag, "_strt_cal"}, strt_cal, 1'b0);
    endtask

    task automatic wait_motors_on(output int t_on);
        bit seen = 1'b0;
        t_on = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!motors_off) begin seen = 1'b1; t_on = cyc; break; end
        end
        check("motors_on_seen", seen, 1'b1);
    endtask

    initial begin
        int t0, t_on, n0;
        logic [7:0] c, exp;

        model_reset();
        #12;
        check_reset_values("reset");
        check("reset_clr", clr_cmd_rdy, 1'b0);
        check("reset_strt_cnv", strt_cnv, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(8'h02, 16'h002A, 1'b1);

        // Calibration: spin-up then cal_done handshake.
        exp = model_apply(8'h06, 16'h0000, batt);
        present(8'h06, 16'h0000, t0);
        wait_motors_on(t_on);
        check("moff_at_decode", t_on - t0, 1);
        check("ical_during_spinup", inertial_cal, 1'b1);
        await_resp(exp, t0, 1'b0);
        check("strt_cal_delay", t_strt_cal - t_on, 15);
        check_state("cal");

        batt = 8'hC3;
        cnv_delay = 40;
        run_frame(8'h01, 16'h0000, 1'b0);
        check("batt_latency", t_send - t_strt_cnv, 42);

        run_frame(8'h03, 16'h8001, 1'b1);
        run_frame(8'h04, 16'h1234, 1'b1);
        run_frame(8'h05, 16'hFFFF, 1'b1);
        run_frame(8'h07, 16'h5555, 1'b1);
        run_frame(8'h02, 16'h0BAD, 1'b1);
        run_frame(8'h3C, 16'h7E7E, 1'b1);
        run_frame(8'h08, 16'h0000, 1'b1);

        // Frame arriving while in CAL waits for the calibration response.
        exp = model_apply(8'h06, 16'h0000, batt);
        present(8'h06, 16'h0000, t0);
        repeat (20) @(negedge clk);
        present(8'h04, 16'hBEEF, t0);
        await_resp(exp, t0, 1'b0);
        check("queued_rdy_held", cmd_rdy, 1'b1);
        exp = model_apply(8'h04, 16'hBEEF, batt);
        await_resp(exp, t0, 1'b0);
        check("queued_cleared", cmd_rdy, 1'b0);
        check_state("queued");

        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 10);
            c = (r <= 8) ? 8'(r) : 8'($urandom_range(9, 255));
            batt = 8'($urandom);
            cnv_delay = $urandom_range(1, 30);
            run_frame(c, 16'($urandom), (c != 8'd1) && (c != 8'd6));
        end

        // Command silence: watchdog build zeroes setpoints silently.
        run_frame(8'h03, 16'h003A, 1'b1);
        run_frame(8'h05, 16'h0123, 1'b1);
        n0 = n_send;
        repeat (100) @(negedge clk);
        check("wdog_early_roll", d_roll, 16'h003A);
        repeat (200) @(negedge clk);
`ifdef CMD_WDOG_EN
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
`endif
        check_state("silence");
        check("silence_no_resp", n_send, n0);

        // Asynchronous reset in the middle of spin-up.
        run_frame(8'h02, 16'h7777, 1'b1);
        present(8'h06, 16'h0000, t0);
        wait_motors_on(t_on);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        n0 = n_send;
        repeat (60) @(negedge clk);
        check("midreset_no_resp", n_send, n0);
        check_state("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
